frame_path_scheduler: RTL and testbench



---
 rtl/frame_path_scheduler.sv | 142 ++++++++++++++
 tb/tb_frame_path_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_path_scheduler.sv
// rtl/frame_path_scheduler.sv - per-beat path routing and frame header sequencing for the dual-path framer
module frame_path_scheduler #(
  parameter int PACKET_SIZE = 2,
  parameter int PP_GROUP    = 2,
  parameter int FRAME_SIZE  = 256,
  parameter int META_LEN    = 1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             data_valid,
  output logic             data_ack,
  input  logic             meta_valid,
  output logic             meta_ack,
  input  logic             out1_ready,
  input  logic             out2_ready,
  output logic             out1_en,
  output logic             out2_en,
  output logic [1:0]       hdr_phase,
  output logic             path_sel,
  output logic [CNT_W-1:0] pkt_count,
  output logic             frame_done
);

  localparam int BEAT_W  = (PACKET_SIZE > 1) ? $clog2(PACKET_SIZE) : 1;
  localparam int GRP_W   = (PP_GROUP > 1)    ? $clog2(PP_GROUP)    : 1;
  localparam int FRAME_W = (FRAME_SIZE > 1)  ? $clog2(FRAME_SIZE)  : 1;
  localparam int META_W  = (META_LEN > 1)    ? $clog2(META_LEN)    : 1;

  localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(PACKET_SIZE - 1);
  localparam logic [GRP_W-1:0]   GRP_LAST   = GRP_W'(PP_GROUP - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_SIZE - 1);
  localparam logic [META_W-1:0]  META_LAST  = META_W'(META_LEN - 1);

  typedef enum logic [1:0] {
    ST_DATA  = 2'd0,
    ST_META  = 2'd1,
    ST_COUNT = 2'd2,
    ST_BAD   = 2'd3
  } state_t;

  state_t             state;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [GRP_W-1:0]   grp_cnt;
  logic [FRAME_W-1:0] frame_cnt;
  logic [META_W-1:0]  meta_cnt;
  logic               xfer;

  assign hdr_phase = state;

  // Header beats are broadcast, so they need both paths ready at once.
  always_comb begin
    xfer     = 1'b0;
    data_ack = 1'b0;
    meta_ack = 1'b0;
    out1_en  = 1'b0;
    out2_en  = 1'b0;
    if (resetn) begin
      case (state)
        ST_DATA: begin
          xfer     = data_valid & (path_sel ? out2_ready : out1_ready);
          data_ack = xfer;
          out1_en  = xfer & ~path_sel;
          out2_en  = xfer & path_sel;
        end
        ST_META: begin
          xfer     = meta_valid & out1_ready & out2_ready;
          meta_ack = xfer;
          out1_en  = xfer;
          out2_en  = xfer;
        end
        ST_COUNT: begin
          xfer    = out1_ready & out2_ready;
          out1_en = xfer;
          out2_en = xfer;
        end
        default: xfer = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_DATA;
      path_sel   <= 1'b0;
      pkt_count  <= '0;
      beat_cnt   <= '0;
      grp_cnt    <= '0;
      frame_cnt  <= '0;
      meta_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_DATA: begin
          if (xfer) begin
            if (beat_cnt == BEAT_LAST) begin
              beat_cnt  <= '0;
              pkt_count <= pkt_count + CNT_W'(1);
              if (grp_cnt == GRP_LAST) begin
                grp_cnt  <= '0;
                path_sel <= ~path_sel;
              end else begin
                grp_cnt <= grp_cnt + GRP_W'(1);
              end
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
            // Packet and frame completion on the same beat both land on this edge.
            if (frame_cnt == FRAME_LAST) begin
              frame_cnt <= '0;
              state     <= ST_META;
            end else begin
              frame_cnt <= frame_cnt + FRAME_W'(1);
            end
          end
        end
        ST_META: begin
          if (xfer) begin
            if (meta_cnt == META_LAST) begin
              meta_cnt <= '0;
              state    <= ST_COUNT;
            end else begin
              meta_cnt <= meta_cnt + META_W'(1);
            end
          end
        end
        ST_COUNT: begin
          // Every frame restarts on path 1 with a fresh group.
          if (xfer) begin
            state      <= ST_DATA;
            frame_done <= 1'b1;
            path_sel   <= 1'b0;
            grp_cnt    <= '0;
          end
        end
        default: state <= ST_DATA;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_path_scheduler.sv
// tb/tb_frame_path_scheduler.sv - directed scenarios and randomized model comparison for frame_path_scheduler
module tb_frame_path_scheduler;

  localparam int PS = 2;
  localparam int PG = 2;
  localparam int FS = 8;
  localparam int ML = 1;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          data_valid = 1'b0;
  logic          meta_valid = 1'b0;
  logic          out1_ready = 1'b0;
  logic          out2_ready = 1'b0;
  logic          data_ack, meta_ack, out1_en, out2_en, path_sel, frame_done;
  logic [1:0]    hdr_phase;
  logic [CW-1:0] pkt_count;

  int checks = 0;
  int failures = 0;

  frame_path_scheduler #(
    .PACKET_SIZE(PS), .PP_GROUP(PG), .FRAME_SIZE(FS), .META_LEN(ML), .CNT_W(CW)
  ) dut (
    .clk(clk), .resetn(resetn),
    .data_valid(data_valid), .data_ack(data_ack),
    .meta_valid(meta_valid), .meta_ack(meta_ack),
    .out1_ready(out1_ready), .out2_ready(out2_ready),
    .out1_en(out1_en), .out2_en(out2_en),
    .hdr_phase(hdr_phase), .path_sel(path_sel),
    .pkt_count(pkt_count), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic rn, input logic dv, input logic mv, input logic r1, input logic r2);
    @(negedge clk);
    resetn = rn; data_valid = dv; meta_valid = mv; out1_ready = r1; out2_ready = r2;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({data_ack, meta_ack, out1_en, out2_en} !== 4'b0000) begin
      failures++; $display("FAIL reset_strobes: got %b want 0000", {data_ack, meta_ack, out1_en, out2_en});
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({hdr_phase, path_sel, pkt_count, frame_done} !== 8'h00) begin
      failures++; $display("FAIL reset_state: got phase=%0d path=%b cnt=%0d done=%b want all 0",
                           hdr_phase, path_sel, pkt_count, frame_done);
    end
  endtask

  task automatic test_full_frame();
    do_reset();
    for (int i = 0; i < FS; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      checks++;
      if ({hdr_phase, data_ack, out1_en, out2_en} !== {2'd0, 1'b1, (i < 4), (i >= 4)}) begin
        failures++; $display("FAIL full_route beat %0d: got phase=%0d ack=%b en1=%b en2=%b want phase=0 ack=1 en1=%b en2=%b",
                             i, hdr_phase, data_ack, out1_en, out2_en, (i < 4), (i >= 4));
      end
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({hdr_phase, meta_ack, data_ack, out1_en, out2_en} !== {2'd1, 4'b1011}) begin
      failures++; $display("FAIL full_meta: got phase=%0d mack=%b dack=%b en=%b%b want phase=1 mack=1 dack=0 en=11",
                           hdr_phase, meta_ack, data_ack, out1_en, out2_en);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({hdr_phase, pkt_count, data_ack, meta_ack, out1_en, out2_en} !== {2'd2, 4'd4, 4'b0011}) begin
      failures++; $display("FAIL full_count: got phase=%0d cnt=%0d acks=%b%b en=%b%b want phase=2 cnt=4 acks=00 en=11",
                           hdr_phase, pkt_count, data_ack, meta_ack, out1_en, out2_en);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({frame_done, hdr_phase, path_sel, out1_en, out2_en} !== {1'b1, 2'd0, 3'b010}) begin
      failures++; $display("FAIL full_restart: got done=%b phase=%0d path=%b en=%b%b want done=1 phase=0 path=0 en=10",
                           frame_done, hdr_phase, path_sel, out1_en, out2_en);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (frame_done !== 1'b0) begin
      failures++; $display("FAIL full_done_pulse: got %b want 0", frame_done);
    end
  endtask

  task automatic test_out2_stall();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({hdr_phase, path_sel, data_ack, out1_en, out2_en} !== {2'd0, 4'b1000}) begin
        failures++; $display("FAIL stall_hold cycle %0d: got phase=%0d path=%b ack=%b en=%b%b want phase=0 path=1 ack=0 en=00",
                             i, hdr_phase, path_sel, data_ack, out1_en, out2_en);
      end
    end
    for (int i = 4; i < FS; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      checks++;
      if ({data_ack, out1_en, out2_en} !== 3'b101) begin
        failures++; $display("FAIL stall_resume beat %0d: got ack=%b en=%b%b want ack=1 en=01",
                             i, data_ack, out1_en, out2_en);
      end
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (hdr_phase !== 2'd1) begin
      failures++; $display("FAIL stall_header: got phase=%0d want 1", hdr_phase);
    end
  endtask

  task automatic test_meta_partial();
    do_reset();
    for (int i = 0; i < FS; i++) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({hdr_phase, meta_ack, out1_en, out2_en} !== {2'd1, 3'b000}) begin
        failures++; $display("FAIL meta_partial cycle %0d: got phase=%0d mack=%b en=%b%b want phase=1 mack=0 en=00",
                             i, hdr_phase, meta_ack, out1_en, out2_en);
      end
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({meta_ack, out1_en, out2_en} !== 3'b111) begin
      failures++; $display("FAIL meta_partial_xfer: got mack=%b en=%b%b want 1 11", meta_ack, out1_en, out2_en);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({hdr_phase, pkt_count} !== {2'd2, 4'd4}) begin
      failures++; $display("FAIL meta_partial_count: got phase=%0d cnt=%0d want phase=2 cnt=4", hdr_phase, pkt_count);
    end
  endtask

  task automatic test_meta_starve();
    do_reset();
    for (int i = 0; i < FS; i++) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      checks++;
      if ({hdr_phase, data_ack, meta_ack, out1_en, out2_en} !== {2'd1, 4'b0000}) begin
        failures++; $display("FAIL meta_starve cycle %0d: got phase=%0d dack=%b mack=%b en=%b%b want phase=1 all 0",
                             i, hdr_phase, data_ack, meta_ack, out1_en, out2_en);
      end
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({meta_ack, data_ack} !== 2'b10) begin
      failures++; $display("FAIL meta_starve_xfer: got mack=%b dack=%b want 1 0", meta_ack, data_ack);
    end
  endtask

  task automatic test_midframe_reset();
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < FS; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      checks++;
      if ({hdr_phase, data_ack} !== {2'd0, 1'b1}) begin
        failures++; $display("FAIL midreset_beat %0d: got phase=%0d ack=%b want phase=0 ack=1", i, hdr_phase, data_ack);
      end
      if (i == 0) begin
        checks++;
        if ({pkt_count, path_sel} !== 5'd0) begin
          failures++; $display("FAIL midreset_state: got cnt=%0d path=%b want 0 0", pkt_count, path_sel);
        end
      end
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({hdr_phase, pkt_count} !== {2'd1, 4'd4}) begin
      failures++; $display("FAIL midreset_header: got phase=%0d cnt=%0d want phase=1 cnt=4", hdr_phase, pkt_count);
    end
  endtask

  task automatic test_count_wrap();
    logic [CW-1:0] want;
    do_reset();
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < FS + ML; i++) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      want = CW'((f + 1) * (FS / PS));
      checks++;
      if ({hdr_phase, pkt_count} !== {2'd2, want}) begin
        failures++; $display("FAIL wrap_count frame %0d: got phase=%0d cnt=%0d want phase=2 cnt=%0d",
                             f, hdr_phase, pkt_count, want);
      end
    end
  endtask

  // Reference model: frame position in data beats, header progress and total beats since reset.
  task automatic test_random();
    int m_phase, m_fbeats, m_meta, m_total;
    logic m_done, rn, dv, mv, r1, r2, x, path;
    logic [12:0] got, want;
    do_reset();
    m_phase = 0; m_fbeats = 0; m_meta = 0; m_total = 0; m_done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rn = ($urandom_range(99) != 0);
      dv = ($urandom_range(3) != 0);
      mv = ($urandom_range(3) != 0);
      r1 = ($urandom_range(4) != 0);
      r2 = ($urandom_range(4) != 0);
      drive(rn, dv, mv, r1, r2);
      path = ((m_fbeats / PS) / PG) % 2;
      case (m_phase)
        0:       x = dv & (path ? r2 : r1);
        1:       x = mv & r1 & r2;
        default: x = r1 & r2;
      endcase
      if (!rn) x = 1'b0;
      want = {2'(m_phase), path, CW'(m_total / PS), m_done,
              x & (m_phase == 0), x & (m_phase == 1),
              x & (m_phase != 0 || !path), x & (m_phase != 0 || path)};
      got = {hdr_phase, path_sel, pkt_count, frame_done, data_ack, meta_ack, out1_en, out2_en};
      checks++;
      if (got !== want) begin
        failures++; $display("FAIL random cycle %0d: got {phase,path,cnt,done,dack,mack,en1,en2}=%h want %h", c, got, want);
      end
      m_done = 1'b0;
      if (!rn) begin
        m_phase = 0; m_fbeats = 0; m_meta = 0; m_total = 0;
      end else if (x) begin
        case (m_phase)
          0: begin
            m_fbeats++; m_total++;
            if (m_fbeats == FS) m_phase = 1;
          end
          1: begin
            m_meta++;
            if (m_meta == ML) begin m_meta = 0; m_phase = 2; end
          end
          default: begin
            m_phase = 0; m_fbeats = 0; m_done = 1'b1;
          end
        endcase
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_out2_stall();
    test_meta_partial();
    test_meta_starve();
    test_midframe_reset();
    test_count_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
